calc_result_display: RTL and testbench
======================================

Name: calc_result_display

Overview:
Downstream stage of the simple calculator datapath. Captures the 17-bit result and its status (overflow flag, divide-by-zero error) when the calculator reaches DONE or ERR. Converts the binary result to six BCD digits with an iterative double-dabble (shift/add-3) engine. Drives the board's 8-digit multiplexed seven-segment display, with leading-zero blanking and status indicators.

Parameters:
DATA_W, 17, width of the binary result input
DIGITS, 6, BCD digits produced (2^17-1 = 131071 fits in 6)
SCAN_BITS, 18, width of the free-running refresh counter; top 3 bits select the active digit

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse: capture Value/Flag/Err and begin conversion (driven on entry to DONE or ERR)
Value  in  DATA_W  binary result (calculator C)
Flag  in  1  overflow / not-divisible indicator from calculator
Err  in  1  divide-by-zero indicator (calculator QErr)
Busy  out  1  conversion in progress
Ready  out  1  Bcd holds a completed conversion
Bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0]
An  out  8  digit anodes, active-low
Ssd  out  8  segments {Dp,Cg,Cf,Ce,Cd,Cc,Cb,Ca}, active-low

Behaviour:
- Reset is asynchronous, active-high; Clk is the clock.
- Reset values: state IDLE, Busy=0, Ready=0, Bcd=0, An=8'hFF, Ssd=8'hFF, scan counter=0, latched Flag/Err=0.
- FSM states: IDLE, CONV, HOLD.
  - IDLE: display dark (An=8'hFF). Start -> CONV.
  - CONV: one shift step per clock for exactly DATA_W clocks, then -> HOLD.
  - HOLD: display active. Start -> CONV (re-capture).
- Capture: on the edge sampling Start in IDLE/HOLD, latch Value into the shift register and latch Flag and Err; clear the working BCD register; load the bit counter with DATA_W.
- Each CONV step:
  - Every working BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - Counter decrements.
- On the edge completing the DATA_W-th step:
  - Working register copies to Bcd atomically (Bcd never shows partial values).
  - Ready=1, Busy=0.
- Latency: Start sampled at edge k gives Busy=1 after edge k, and Bcd/Ready valid after edge k+DATA_W (k+17).
- Ready clears on the edge that accepts a new Start.
- Bcd holds its previous value during CONV.
- Start while in CONV is ignored; no queuing.
- Start and reset together: reset wins.
- Reset mid-conversion: returns to IDLE with all reset values; no partial result.
- If Err was latched, the conversion still runs, but the display ignores Bcd.
- Scan counter:
  - Free-running, wraps at 2^SCAN_BITS.
  - Digit index i = counter[SCAN_BITS-1 -: 3].
  - Exactly one An bit is low at a time, and only for enabled digits.
- Display mapping in HOLD, Err=0:
  - Digits 0-5 show Bcd nibbles.
  - Leading zeros are blanked; digit 0 is always shown.
  - Digit 6: blank segments, Dp lit iff Flag latched.
  - Digit 7: anode off.
- Display mapping in HOLD, Err=1: digits 0-6 anode off; digit 7 shows 'E' (8'h86).
- Blanked digit: anode stays high.
- An and Ssd are registered: one-cycle delay from counter, glitch-free.
- Hex decode (active-low, Dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Nibbles are guaranteed <= 9 by construction; anything else decodes to blank (FF).

Decomposition:
- Package calc_disp_pkg:
  - FSM state encodings (one-hot, 3 bits).
  - Segment constants (SEG_0..SEG_9, SEG_E, SEG_BLANK).
  - DIGITS and DATA_W defaults.
- Sub-module calc_bin2bcd: the sequential double-dabble engine with Start/Busy/Ready/Bcd. It is reusable and separately testable.
- The top level adds capture of Flag/Err, the scan counter, blanking and segment decode.

Test Plan:
- Value=17'd131071, Flag=0, Err=0, pulse Start -> Busy for 17 cycles, Bcd=24'h131071, Ready=1; scan shows digits 0-5 as 1,7,0,1,3,1; An[6], An[7] never low.
- Value=0 -> Bcd=24'h000000; only An[0] ever goes low, with Ssd=8'hC0.
- Value=12345, Flag=1 -> Bcd=24'h012345; digit 5 blanked; when i=6, An[6]=0 and Ssd=8'h7F (Dp only).
- Err=1, Value=X, Start -> after 17 cycles only An[7] goes low, Ssd=8'h86; digits 0-6 dark.
- Start with Value=100, then Start again at cycle 5 with Value=999 -> second Start ignored; Bcd=24'h000100 at cycle 17; Bcd stays 000100 until the next accepted Start.
- Reset asserted at cycle 9 of a conversion -> immediately Busy=0, Ready=0, Bcd=0, An=8'hFF; a later Start with Value=42 gives Bcd=24'h000042 after 17 cycles.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display: FSM encodings,
// active-low segment patterns and the BCD-to-segment decode.
package calc_disp_pkg;

  localparam int unsigned DEF_DATA_W = 17;
  localparam int unsigned DEF_DIGITS = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_CONV = 3'b010,
    ST_HOLD = 3'b100
  } state_e;

  // Segment order {Dp,Cg,Cf,Ce,Cd,Cc,Cb,Ca}, active-low
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_DP    = 8'h7F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock, DATA_W steps
// per conversion; Bcd updates only when a conversion completes.
module calc_bin2bcd
  import calc_disp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     Value,
  output logic                  Busy,
  output logic                  Ready,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   work_q, work_d, adj, bcd_q, bcd_d, work_shift;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, last_step;

  assign accept    = Start && (state_q != ST_CONV);
  assign last_step = (state_q == ST_CONV) && (cnt_q == CNT_W'(1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HOLD: if (Start) state_d = ST_CONV;
      ST_CONV:          if (last_step) state_d = ST_HOLD;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state_q == ST_CONV);
    Ready = (state_q == ST_HOLD);
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];
    end
    // Top bit of the adjusted register falls off; it is always zero for in-range inputs
    work_shift = BCD_W'({adj, bin_q[DATA_W-1]});
  end

  always_comb begin
    work_d = work_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    if (accept) begin
      work_d = '0;
      bin_d  = Value;
      cnt_d  = CNT_W'(DATA_W);
    end else if (state_q == ST_CONV) begin
      work_d = work_shift;
      bin_d  = {bin_q[DATA_W-2:0], 1'b0};
      cnt_d  = cnt_q - CNT_W'(1);
      if (last_step) bcd_d = work_shift;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      work_q <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
    end else begin
      work_q <= work_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
    end
  end

  assign Bcd = bcd_q;

endmodule

// File: rtl/calc_result_display.sv
// Calculator result display: latches result status, converts to BCD and scans an
// 8-digit multiplexed seven-segment display with leading-zero blanking.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DIGITS    = DEF_DIGITS,
  parameter int unsigned SCAN_BITS = 18
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     Value,
  input  logic                  Flag,
  input  logic                  Err,
  output logic                  Busy,
  output logic                  Ready,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [7:0]            An,
  output logic [7:0]            Ssd
);

  logic                  flag_q, err_q;
  logic [SCAN_BITS-1:0]  scan_q;
  logic [2:0]            idx;
  logic [7:0]            en;
  logic [31:0]           bcd_ext;
  logic [3:0]            nib;
  logic [7:0]            an_d, an_q, ssd_d, ssd_q;

  calc_bin2bcd #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Value (Value),
    .Busy  (Busy),
    .Ready (Ready),
    .Bcd   (Bcd)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
      if (Start && !Busy) begin
        flag_q <= Flag;
        err_q  <= Err;
      end
    end
  end

  assign idx     = scan_q[SCAN_BITS-1 -: 3];
  assign bcd_ext = 32'(Bcd);
  assign nib     = bcd_ext[{idx, 2'b00} +: 4];

  // A digit is shown when it or any more significant digit is nonzero
  always_comb begin
    en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      en[i] = ((bcd_ext >> (4 * i)) != 32'd0);
    end
    en[0] = 1'b1;
  end

  always_comb begin
    an_d  = 8'hFF;
    ssd_d = SEG_BLANK;
    if (Ready) begin
      if (err_q) begin
        if (idx == 3'd7) begin
          an_d[7] = 1'b0;
          ssd_d   = SEG_E;
        end
      end else if (idx == 3'd6) begin
        if (flag_q) begin
          an_d[6] = 1'b0;
          ssd_d   = SEG_DP;
        end
      end else if (en[idx]) begin
        an_d[idx] = 1'b0;
        ssd_d     = seg_decode(nib);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      an_q  <= 8'hFF;
      ssd_q <= 8'hFF;
    end else begin
      an_q  <= an_d;
      ssd_q <= ssd_d;
    end
  end

  assign An  = an_q;
  assign Ssd = ssd_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed self-checking bench for calc_result_display (short scan counter for speed).
module tb_calc_result_display;

  localparam int unsigned DATA_W    = 17;
  localparam int unsigned DIGITS    = 6;
  localparam int unsigned SCAN_BITS = 6;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic [16:0]       Value;
  logic              Flag;
  logic              Err;
  logic              Busy;
  logic              Ready;
  logic [23:0]       Bcd;
  logic [7:0]        An;
  logic [7:0]        Ssd;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  calc_result_display #(
    .DATA_W    (DATA_W),
    .DIGITS    (DIGITS),
    .SCAN_BITS (SCAN_BITS)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Value (Value),
    .Flag  (Flag),
    .Err   (Err),
    .Busy  (Busy),
    .Ready (Ready),
    .Bcd   (Bcd),
    .An    (An),
    .Ssd   (Ssd)
  );

  task automatic pulse_start(input logic [16:0] v, input logic f, input logic e);
    @(negedge Clk);
    Start = 1'b1; Value = v; Flag = f; Err = e;
    @(negedge Clk);
    Start = 1'b0; Value = '0; Flag = 1'b0; Err = 1'b0;
  endtask

  task automatic run_conv(input string name, input logic [16:0] v, input logic f,
                          input logic e, input logic [23:0] exp_bcd);
    int bad = 0;
    pulse_start(v, f, e);
    for (int i = 0; i <= 16; i++) begin
      if (Busy !== 1'b1 || Ready !== 1'b0) bad++;
      if (i < 16) @(negedge Clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_busy: got %0d bad cycles, expected 0", name, bad);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Ready !== 1'b1 || Bcd !== exp_bcd) begin
      failures++;
      $display("FAIL %s_done: got busy=%b ready=%b bcd=%h, expected busy=0 ready=1 bcd=%h",
               name, Busy, Ready, Bcd, exp_bcd);
    end
  endtask

  task automatic observe(input string name, input logic [7:0] exp_mask,
                         input logic [63:0] exp_ssd);
    logic [7:0] seen = '0;
    int ssd_bad = 0;
    int multi   = 0;
    int lows;
    for (int n = 0; n < 80; n++) begin
      @(negedge Clk);
      lows = 0;
      for (int d = 0; d < 8; d++) begin
        if (An[d] === 1'b0) begin
          lows++;
          seen[d] = 1'b1;
          if (Ssd !== exp_ssd[8*d +: 8]) ssd_bad++;
        end
      end
      if (lows > 1) multi++;
    end
    checks++;
    if (seen !== exp_mask) begin
      failures++;
      $display("FAIL %s_anodes: got lit mask %h, expected %h", name, seen, exp_mask);
    end
    checks++;
    if (ssd_bad != 0) begin
      failures++;
      $display("FAIL %s_segments: got %0d wrong segment samples, expected 0", name, ssd_bad);
    end
    checks++;
    if (multi != 0) begin
      failures++;
      $display("FAIL %s_onehot: got %0d multi-anode samples, expected 0", name, multi);
    end
  endtask

  task automatic test_reset();
    int dark_bad = 0;
    Reset = 1'b1; Start = 1'b0; Value = '0; Flag = 1'b0; Err = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Ready !== 1'b0 || Bcd !== 24'h0 || An !== 8'hFF || Ssd !== 8'hFF) begin
      failures++;
      $display("FAIL reset_values: got busy=%b ready=%b bcd=%h an=%h ssd=%h, expected 0 0 0 ff ff",
               Busy, Ready, Bcd, An, Ssd);
    end
    Start = 1'b1; Value = 17'd5;
    @(negedge Clk);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins: got busy=%b, expected 0", Busy);
    end
    Reset = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge Clk);
      if (An !== 8'hFF || Busy !== 1'b0) dark_bad++;
    end
    checks++;
    if (dark_bad != 0) begin
      failures++;
      $display("FAIL idle_dark: got %0d non-idle samples, expected 0", dark_bad);
    end
  endtask

  task automatic test_max();
    run_conv("max", 17'd131071, 1'b0, 1'b0, 24'h131071);
    observe("max", 8'h3F, {8'hFF, 8'hFF, 8'hF9, 8'hB0, 8'hF9, 8'hC0, 8'hF8, 8'hF9});
  endtask

  task automatic test_zero();
    run_conv("zero", 17'd0, 1'b0, 1'b0, 24'h000000);
    observe("zero", 8'h01, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
  endtask

  task automatic test_flag();
    run_conv("flag", 17'd12345, 1'b1, 1'b0, 24'h012345);
    observe("flag", 8'h5F, {8'hFF, 8'h7F, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92});
  endtask

  task automatic test_err();
    run_conv("err", 17'h1ABCD, 1'b0, 1'b1, 24'h109517);
    observe("err", 8'h80, {8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
  endtask

  task automatic test_ignore_start();
    int bad = 0;
    int hold_bad = 0;
    pulse_start(17'd100, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        Start = 1'b1; Value = 17'd999;
      end else begin
        Start = 1'b0; Value = '0;
      end
      if (Bcd !== 24'h109517 || Ready !== 1'b0) bad++;
      @(negedge Clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL conv_hold_bcd: got %0d cycles with changed bcd or ready, expected 0", bad);
    end
    @(negedge Clk);
    checks++;
    if (Bcd !== 24'h000100 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_result: got bcd=%h ready=%b, expected bcd=000100 ready=1", Bcd, Ready);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (Busy !== 1'b0 || Bcd !== 24'h000100) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL no_queue: got %0d samples busy or changed, expected 0", hold_bad);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(17'd777, 1'b0, 1'b0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Ready !== 1'b0 || Bcd !== 24'h0 || An !== 8'hFF || Ssd !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b ready=%b bcd=%h an=%h ssd=%h, expected 0 0 0 ff ff",
               Busy, Ready, Bcd, An, Ssd);
    end
    @(negedge Clk);
    Reset = 1'b0;
    run_conv("after_reset", 17'd42, 1'b0, 1'b0, 24'h000042);
  endtask

  task automatic test_back_to_back();
    run_conv("b2b", 17'd99999, 1'b0, 1'b0, 24'h099999);
    observe("b2b", 8'h1F, {8'hFF, 8'hFF, 8'hFF, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_flag();
    test_err();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
